// File: rtl/inst_rom_responder_pkg.sv
// Shared constants, state encoding and array word width for the instruction ROM responder.
// INST_ROM_PARITY_EN widens each stored word by one parity bit.
package inst_rom_responder_pkg;

  localparam int          INST_W     = 32;
  localparam logic [31:0] NOP_INST   = 32'h0;
  localparam logic [31:0] ZERO_WORD  = 32'h0;
  localparam logic        RST_ACTIVE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } load_state_e;

`ifdef INST_ROM_PARITY_EN
  localparam int MEM_W = INST_W + 1;
`else
  localparam int MEM_W = INST_W;
`endif

endpackage

// File: rtl/inst_rom_responder_boot_load_fsm.sv
// Boot-load sequencer: IDLE/LOAD/RUN state, length capture, write pointer, load handshake.
// Latency: one beat per cycle while loading; load_done pulses the cycle after the last beat.
// Backpressure: load_ready is high only in LOAD; beats outside LOAD are dropped.
module inst_rom_responder_boot_load_fsm
  import inst_rom_responder_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int AUTO_RUN = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              load_valid,
  output logic              load_ready,
  output logic              load_done,
  output logic              core_hold,
  output logic              run,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr
);

  localparam logic [ADDR_W:0] MAX_LEN   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LEN_ONE   = (ADDR_W+1)'(1);
  localparam load_state_e     RST_STATE = (AUTO_RUN != 0) ? ST_RUN : ST_IDLE;

  load_state_e       state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic              load_done_q, load_done_d;

  logic [ADDR_W:0] start_len;
  logic            accept;
  logic            last_beat;

  assign start_len = (load_len > MAX_LEN) ? MAX_LEN : load_len;
  assign accept    = load_valid && (state_q == ST_LOAD);
  assign last_beat = ({1'b0, wr_ptr_q} == (len_q - LEN_ONE));

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    wr_ptr_d    = wr_ptr_q;
    load_done_d = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_RUN: begin
        if (load_start) begin
          len_d = start_len;
          // Zero-length session completes immediately without touching the array.
          if (start_len == '0) begin
            state_d     = ST_RUN;
            load_done_d = 1'b1;
          end else begin
            state_d  = ST_LOAD;
            wr_ptr_d = '0;
          end
        end
      end
      ST_LOAD: begin
        if (accept) begin
          if (last_beat) begin
            state_d     = ST_RUN;
            wr_ptr_d    = '0;
            load_done_d = 1'b1;
          end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
        end
      end
      default: state_d = RST_STATE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ACTIVE) begin
      state_q     <= RST_STATE;
      len_q       <= '0;
      wr_ptr_q    <= '0;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      wr_ptr_q    <= wr_ptr_d;
      load_done_q <= load_done_d;
    end
  end

  assign load_ready = (state_q == ST_LOAD);
  assign load_done  = load_done_q;
  assign core_hold  = (state_q != ST_RUN);
  assign run        = (state_q == ST_RUN);
  // A beat presented during the reset cycle must not corrupt the array.
  assign wr_en      = accept && (rst != RST_ACTIVE);
  assign wr_addr    = wr_ptr_q;

endmodule

// File: rtl/inst_rom_responder.sv
// Instruction ROM responder: boot-loaded word array serving core fetches combinationally in RUN.
// Latency: rom_data 0 cycles; range_err/parity_err 1 cycle. Backpressure: via load_ready only.
// Optional INST_ROM_PARITY_EN stores a parity bit per word and flags mismatching fetches.
module inst_rom_responder
  import inst_rom_responder_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int AUTO_RUN = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rom_en,
  input  logic [31:0]     rom_addr,
  output logic [31:0]     rom_data,
  input  logic            load_start,
  input  logic [ADDR_W:0] load_len,
  input  logic            load_valid,
  input  logic [31:0]     load_data,
  output logic            load_ready,
  output logic            load_done,
  output logic            core_hold,
  output logic            range_err,
  output logic            parity_err
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [MEM_W-1:0]  mem_q [DEPTH];
  logic              run;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [MEM_W-1:0]  wr_word;
  logic [ADDR_W-1:0] idx;
  logic              in_range;
  logic              rd_vld;
  logic [MEM_W-1:0]  rd_word;
  logic              parity_bad;
  logic              range_err_q, range_err_d;
  logic              unused_addr_lsb;

  inst_rom_responder_boot_load_fsm #(
    .ADDR_W   (ADDR_W),
    .AUTO_RUN (AUTO_RUN)
  ) u_boot_load_fsm (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .load_len   (load_len),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_done  (load_done),
    .core_hold  (core_hold),
    .run        (run),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr)
  );

  // Byte address from the core; the word index drops the two byte-lane bits.
  assign idx             = rom_addr[ADDR_W+1:2];
  assign in_range        = (rom_addr[31:ADDR_W+2] == '0);
  assign unused_addr_lsb = ^rom_addr[1:0];
  assign rd_vld          = run && rom_en && in_range;
  assign rd_word         = mem_q[idx];

`ifdef INST_ROM_PARITY_EN
  logic parity_err_q, parity_err_d;

  assign wr_word      = {^load_data, load_data};
  assign parity_bad   = rd_vld && ((^rd_word[31:0]) != rd_word[32]);
  assign parity_err_d = parity_err_q || parity_bad;

  always_ff @(posedge clk) begin
    if (rst == RST_ACTIVE) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_err = parity_err_q;
`else
  assign wr_word    = load_data;
  assign parity_bad = 1'b0;
  assign parity_err = 1'b0;
`endif

  // Array is deliberately not reset so a reset does not wipe a loaded image.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_word;
    end
  end

  always_comb begin
    rom_data = NOP_INST;
    if (rd_vld && !parity_bad) begin
      rom_data = rd_word[31:0];
    end
  end

  assign range_err_d = run && rom_en && !in_range;

  always_ff @(posedge clk) begin
    if (rst == RST_ACTIVE) begin
      range_err_q <= 1'b0;
    end else begin
      range_err_q <= range_err_d;
    end
  end

  assign range_err = range_err_q;

endmodule

// File: tb/tb_inst_rom_responder.sv
// Directed bench for inst_rom_responder: boot load, fetch, range, reset-abort, reload and
// length clamping; parity fault injection when INST_ROM_PARITY_EN is defined.
module tb_inst_rom_responder;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  logic            clk = 1'b0;
  logic            rst;
  logic            rom_en;
  logic [31:0]     rom_addr;
  logic [31:0]     rom_data;
  logic            load_start;
  logic [ADDR_W:0] load_len;
  logic            load_valid;
  logic [31:0]     load_data;
  logic            load_ready;
  logic            load_done;
  logic            core_hold;
  logic            range_err;
  logic            parity_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [DEPTH];
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  inst_rom_responder #(
    .ADDR_W   (ADDR_W),
    .AUTO_RUN (0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rom_en     (rom_en),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .load_start (load_start),
    .load_len   (load_len),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .load_done  (load_done),
    .core_hold  (core_hold),
    .range_err  (range_err),
    .parity_err (parity_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a fetch, push the model's answer, then pop and compare once rom_data settles.
  task automatic fetch(input string tag, input logic en, input logic [31:0] addr);
    logic [31:0] exp;
    rom_en   = en;
    rom_addr = addr;
    exp = 32'h0;
    if (en && (addr[31:ADDR_W+2] == '0)) exp = model[addr[ADDR_W+1:2]];
    exp_q.push_back(exp);
    #1;
    chk(tag, rom_data, exp_q.pop_front());
  endtask

  task automatic beat(input logic [31:0] d, input int unsigned slot);
    load_valid = 1'b1;
    load_data  = d;
    model[slot] = d;
    tick();
    load_valid = 1'b0;
  endtask

  initial begin
    rst        = 1'b0;
    rom_en     = 1'b1;
    rom_addr   = 32'h0;
    load_start = 1'b0;
    load_len   = '0;
    load_valid = 1'b0;
    load_data  = 32'h0;
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;

    // Held in reset with a fetch pending: everything quiet.
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("rst_core_hold", {31'b0, core_hold}, 32'd1);
      chk("rst_load_ready", {31'b0, load_ready}, 32'd0);
      chk("rst_rom_data", rom_data, 32'h0);
    end
    chk("rst_range_err", {31'b0, range_err}, 32'd0);
    chk("rst_parity_err", {31'b0, parity_err}, 32'd0);
    chk("rst_load_done", {31'b0, load_done}, 32'd0);

    // Four-beat load with a valid gap after beat 2.
    rst = 1'b1;
    rom_en = 1'b0;
    tick();
    chk("idle_hold", {31'b0, core_hold}, 32'd1);
    load_start = 1'b1;
    load_len   = 11'd4;
    tick();
    load_start = 1'b0;
    chk("load_ready_up", {31'b0, load_ready}, 32'd1);
    fetch("load_nop", 1'b1, 32'h0);
    rom_en = 1'b0;
    beat(32'h11111111, 0);
    beat(32'h22222222, 1);
    tick();
    chk("gap_no_done", {31'b0, load_done}, 32'd0);
    beat(32'h33333333, 2);
    chk("before_last_done", {31'b0, load_done}, 32'd0);
    beat(32'h44444444, 3);
    chk("load_done_pulse", {31'b0, load_done}, 32'd1);
    chk("run_core_hold", {31'b0, core_hold}, 32'd0);
    chk("run_load_ready", {31'b0, load_ready}, 32'd0);
    fetch("fetch_8", 1'b1, 32'h8);
    tick();
    chk("load_done_single", {31'b0, load_done}, 32'd0);

    // Range error is registered and clears on the next in-range fetch.
    fetch("fetch_oor", 1'b1, 32'h0000_1000);
    tick();
    chk("range_err_set", {31'b0, range_err}, 32'd1);
    fetch("fetch_4", 1'b1, 32'h4);
    fetch("fetch_5_lsb_ignored", 1'b1, 32'h5);
    tick();
    chk("range_err_clr", {31'b0, range_err}, 32'd0);
    fetch("fetch_en0", 1'b0, 32'hC);

    // Reprogram from RUN, then reset after two beats.
    load_start = 1'b1;
    load_len   = 11'd4;
    tick();
    load_start = 1'b0;
    chk("reprog_hold", {31'b0, core_hold}, 32'd1);
    beat(32'h55555555, 0);
    beat(32'h66666666, 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("abort_hold", {31'b0, core_hold}, 32'd1);
    chk("abort_ready", {31'b0, load_ready}, 32'd0);
    chk("abort_no_done", {31'b0, load_done}, 32'd0);
    tick();
    chk("abort_no_done2", {31'b0, load_done}, 32'd0);

    // One-word load restarts at index 0.
    load_start = 1'b1;
    load_len   = 11'd1;
    tick();
    load_start = 1'b0;
    beat(32'hAAAA_AAAA, 0);
    chk("len1_done", {31'b0, load_done}, 32'd1);
    fetch("len1_w0", 1'b1, 32'h0);
    fetch("len1_w1_kept", 1'b1, 32'h4);
    fetch("len1_w2_kept", 1'b1, 32'h8);

    // Zero-length load from IDLE accepts nothing.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    rom_en = 1'b0;
    load_start = 1'b1;
    load_len   = 11'd0;
    load_valid = 1'b1;
    load_data  = 32'hDEAD_BEEF;
    tick();
    load_start = 1'b0;
    load_valid = 1'b0;
    chk("len0_done", {31'b0, load_done}, 32'd1);
    chk("len0_run", {31'b0, core_hold}, 32'd0);
    chk("len0_ready", {31'b0, load_ready}, 32'd0);
    fetch("len0_w0", 1'b1, 32'h0);
    tick();
    chk("len0_done_clr", {31'b0, load_done}, 32'd0);

    // Two-word reprogram; load_start on the final beat is ignored.
    load_start = 1'b1;
    load_len   = 11'd2;
    tick();
    load_start = 1'b0;
    chk("len2_hold", {31'b0, core_hold}, 32'd1);
    chk("len2_ready", {31'b0, load_ready}, 32'd1);
    beat(32'h77777777, 0);
    load_start = 1'b1;
    beat(32'h88888888, 1);
    load_start = 1'b0;
    chk("len2_done", {31'b0, load_done}, 32'd1);
    chk("len2_run", {31'b0, core_hold}, 32'd0);
    tick();
    chk("final_start_ignored", {31'b0, core_hold}, 32'd0);
    fetch("len2_w0", 1'b1, 32'h0);
    fetch("len2_w1", 1'b1, 32'h4);

    // Oversized length clamps to the array depth.
    rom_en = 1'b0;
    load_start = 1'b1;
    load_len   = 11'd2047;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) beat(32'hC000_0000 | 32'(i), i);
    chk("clamp_not_done", {31'b0, load_done}, 32'd0);
    chk("clamp_still_ready", {31'b0, load_ready}, 32'd1);
    beat(32'hC000_03FF, DEPTH - 1);
    chk("clamp_done", {31'b0, load_done}, 32'd1);
    fetch("clamp_top", 1'b1, 32'h0000_0FFC);
    fetch("clamp_mid", 1'b1, 32'h0000_0800);
    chk("no_parity_err", {31'b0, parity_err}, 32'd0);

`ifdef INST_ROM_PARITY_EN
    dut.mem_q[0][5] = ~dut.mem_q[0][5];
    rom_en   = 1'b1;
    rom_addr = 32'h0;
    exp_q.push_back(32'h0);
    #1;
    chk("parity_zeroed", rom_data, exp_q.pop_front());
    tick();
    chk("parity_err_set", {31'b0, parity_err}, 32'd1);
    fetch("parity_other_word", 1'b1, 32'h4);
    tick();
    chk("parity_err_sticky", {31'b0, parity_err}, 32'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("parity_err_rst", {31'b0, parity_err}, 32'd0);
`endif

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
